irq_entry_sequencer: RTL and testbench
======================================

// Module: irq_entry_sequencer
// PURPOSE
//  CPU-side consumer of the vectored interrupt controller outputs (irq_pending/irq_num/irq_vector).
//  Freezes fetch, waits for pipeline drain, saves return PC + IRQ number on a nesting stack,
//  acks the controller, redirects fetch to the vector. On mret, pops context, redirects back, issues EOI.
// PARAMETERS
//  VECTOR_WIDTH  8   width of irq_vector from the controller
//  PC_WIDTH      32  program counter width
//  VEC_SHIFT     2   handler PC = zero_ext(irq_vector) << VEC_SHIFT
//  MAX_NEST      4   context stack depth (max nested ISRs)
// PORTS
//  clk            in   1                rising-edge clock
//  rst            in   1                synchronous active-high reset
//  irq_pending    in   1                controller has an enabled, not-in-service IRQ
//  irq_num        in   4                highest-priority IRQ number
//  irq_vector     in   VECTOR_WIDTH     vector for irq_num
//  global_ie      in   1                CPU global interrupt enable
//  pipe_drained   in   1                no in-flight instructions past fetch
//  resume_pc      in   PC_WIDTH         PC of next unexecuted instruction (valid when drained)
//  mret           in   1                one-cycle pulse: ISR return retired
//  stall_req      out  1                freeze fetch/issue
//  irq_ack        out  1                one-cycle ack pulse to controller
//  irq_ack_num    out  4                IRQ being acked
//  redirect_valid out  1                one-cycle fetch redirect pulse
//  redirect_pc    out  PC_WIDTH         redirect target
//  eoi_valid      out  1                one-cycle end-of-interrupt pulse
//  eoi_num        out  4                IRQ completed
//  nest_depth     out  $clog2(MAX_NEST+1)  current stack occupancy
//  mret_err       out  1                one-cycle pulse: mret with empty stack
// BEHAVIOUR
//  Single clock clk; reset rst synchronous, active-high. Reset: state IDLE, stack empty, all outputs 0.
//  States: IDLE, DRAIN, ACK, REDIRECT, RETURN. All outputs are registered/Moore-decoded from state.
//  stall_req = (state != IDLE).
//  IDLE: priority 1: mret -> if depth>0 pop {pc,num} into hold regs, go RETURN; else pulse mret_err next
//    cycle, stay IDLE. Priority 2: irq_pending & global_ie & depth<MAX_NEST -> latch irq_num/irq_vector, go DRAIN.
//    depth==MAX_NEST: pending IRQ ignored (no stall).
//  DRAIN: if !irq_pending -> abort to IDLE, nothing pushed/acked. Else relatch irq_num/irq_vector each cycle
//    (higher-priority arrival wins). If pipe_drained: push {resume_pc, num}, go ACK.
//  ACK: irq_ack=1, irq_ack_num=latched num for exactly this cycle; go REDIRECT.
//  REDIRECT: redirect_valid=1, redirect_pc = zero_ext(vector)<<VEC_SHIFT, truncated to PC_WIDTH; go IDLE.
//  RETURN: redirect_valid=1, redirect_pc=popped pc, eoi_valid=1, eoi_num=popped num; go IDLE.
//  mret outside IDLE: ignored (pipeline is stalled; cannot legally occur); no error pulse.
//  Min latency irq_pending@IDLE (cycle 0, drained) -> DRAIN c1 -> irq_ack c2 -> redirect c3 -> IDLE c4.
//  Nesting: after REDIRECT a new pending IRQ may be taken again (controller masks in-service IRQs).
//  Push and pop never occur in the same cycle. nest_depth updates the cycle after push/pop.
//  Reset mid-sequence: abandons sequence, empties stack, no ack/redirect/eoi pulses emitted.
// STRUCTURE
//  Shared package: state encoding localparams, IRQ_NUM_W=4, default PC_WIDTH/VECTOR_WIDTH.
//  Sub-module irq_ctx_stack: LIFO, MAX_NEST x (PC_WIDTH+4), push/pop/full/empty/count, sync reset.
//  Top: FSM + latch regs + output decode.
// TESTING
//  drained=1, irq_num=5, vector=0x10, ie=1 -> ack num 5 at c2, redirect_pc=0x40 at c3, depth=1.
//  drained=0 for 3 cycles, irq_num 5->2 in DRAIN -> stall held, ack num 2, pushed resume_pc at drain cycle.
//  irq_pending drops in DRAIN -> back to IDLE, no ack/redirect, depth unchanged, stall released.
//  Nest 4 IRQs (MAX_NEST=4), 5th pending -> ignored, stall_req stays 0; 4 mret -> LIFO PCs/eoi_num order.
//  mret with depth 0 -> mret_err pulse, no redirect/eoi; mret+irq_pending same cycle -> RETURN taken first.
//  rst asserted in ACK state -> next cycle all outputs 0, depth 0, no irq_ack pulse.

Source files
------------

// File: rtl/irq_entry_sequencer_pkg.sv
// Shared definitions for the interrupt entry/return sequencer.
// Holds the FSM state encoding and the default widths used by the top and the context stack.
package irq_entry_sequencer_pkg;

  localparam int IRQ_NUM_W        = 4;
  localparam int DEF_PC_WIDTH     = 32;
  localparam int DEF_VECTOR_WIDTH = 8;
  localparam int DEF_VEC_SHIFT    = 2;
  localparam int DEF_MAX_NEST     = 4;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_DRAIN    = 3'd1,
    ST_ACK      = 3'd2,
    ST_REDIRECT = 3'd3,
    ST_RETURN   = 3'd4
  } seq_state_e;

endpackage

// File: rtl/irq_entry_sequencer_ctx_stack.sv
// LIFO of saved interrupt contexts ({return pc, irq number}).
// The top entry is read combinationally so a pop can latch it in the same cycle.
module irq_ctx_stack
  import irq_entry_sequencer_pkg::*;
#(
  parameter int DEPTH  = DEF_MAX_NEST,
  parameter int DATA_W = DEF_PC_WIDTH + IRQ_NUM_W
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [DATA_W-1:0]          push_data,
  output logic [DATA_W-1:0]          top_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [CNT_W-1:0]  count_q;
  logic [IDX_W-1:0]  wr_idx;
  logic [IDX_W-1:0]  rd_idx;

  assign wr_idx   = IDX_W'(count_q);
  assign rd_idx   = IDX_W'(count_q - 1'b1);
  assign full     = (count_q == CNT_W'(DEPTH));
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign top_data = mem[rd_idx];

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else if (push && !full) begin
      count_q <= count_q + 1'b1;
    end else if (pop && !empty) begin
      count_q <= count_q - 1'b1;
    end
  end

  // Storage needs no reset: occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push && !full) begin
      mem[wr_idx] <= push_data;
    end
  end

endmodule

// File: rtl/irq_entry_sequencer.sv
// Takes a pending vectored interrupt into the CPU (stall, drain, save context, ack, redirect)
// and unwinds it on mret (pop context, redirect back, end-of-interrupt).
//
// state    | meaning
// IDLE     | running normally; accepts mret or a new interrupt
// DRAIN    | fetch frozen, waiting for the pipeline to empty; IRQ choice may still change
// ACK      | context saved; acknowledge the IRQ to the controller
// REDIRECT | steer fetch to the handler entry
// RETURN   | steer fetch back to the saved pc and signal end-of-interrupt
module irq_entry_sequencer
  import irq_entry_sequencer_pkg::*;
#(
  parameter int VECTOR_WIDTH = DEF_VECTOR_WIDTH,
  parameter int PC_WIDTH     = DEF_PC_WIDTH,
  parameter int VEC_SHIFT    = DEF_VEC_SHIFT,
  parameter int MAX_NEST     = DEF_MAX_NEST
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          irq_pending,
  input  logic [IRQ_NUM_W-1:0]          irq_num,
  input  logic [VECTOR_WIDTH-1:0]       irq_vector,
  input  logic                          global_ie,
  input  logic                          pipe_drained,
  input  logic [PC_WIDTH-1:0]           resume_pc,
  input  logic                          mret,
  output logic                          stall_req,
  output logic                          irq_ack,
  output logic [IRQ_NUM_W-1:0]          irq_ack_num,
  output logic                          redirect_valid,
  output logic [PC_WIDTH-1:0]           redirect_pc,
  output logic                          eoi_valid,
  output logic [IRQ_NUM_W-1:0]          eoi_num,
  output logic [$clog2(MAX_NEST+1)-1:0] nest_depth,
  output logic                          mret_err
);

  localparam int CTX_W = PC_WIDTH + IRQ_NUM_W;

  seq_state_e                  state_q, state_d;
  logic [IRQ_NUM_W-1:0]        num_q;
  logic [VECTOR_WIDTH-1:0]     vec_q;
  logic [PC_WIDTH-1:0]         ret_pc_q;
  logic [IRQ_NUM_W-1:0]        ret_num_q;
  logic                        mret_err_q;
  logic                        push, pop;
  logic                        stk_full, stk_empty;
  logic [CTX_W-1:0]            stk_top;
  logic [PC_WIDTH-1:0]         handler_pc;

  irq_ctx_stack #(
    .DEPTH  (MAX_NEST),
    .DATA_W (CTX_W)
  ) u_ctx_stack (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .pop       (pop),
    .push_data ({resume_pc, irq_num}),
    .top_data  (stk_top),
    .full      (stk_full),
    .empty     (stk_empty),
    .count     (nest_depth)
  );

  always_comb begin
    state_d = state_q;
    push    = 1'b0;
    pop     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (mret) begin
          if (!stk_empty) begin
            pop     = 1'b1;
            state_d = ST_RETURN;
          end
        end else if (irq_pending && global_ie && !stk_full) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (!irq_pending) begin
          state_d = ST_IDLE;
        end else if (pipe_drained) begin
          push    = 1'b1;
          state_d = ST_ACK;
        end
      end
      ST_ACK:      state_d = ST_REDIRECT;
      ST_REDIRECT: state_d = ST_IDLE;
      ST_RETURN:   state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      num_q      <= '0;
      vec_q      <= '0;
      ret_pc_q   <= '0;
      ret_num_q  <= '0;
      mret_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      mret_err_q <= (state_q == ST_IDLE) && mret && stk_empty;
      // Keep tracking the controller's choice until the context is pushed.
      if (((state_q == ST_IDLE) && (state_d == ST_DRAIN)) ||
          ((state_q == ST_DRAIN) && irq_pending)) begin
        num_q <= irq_num;
        vec_q <= irq_vector;
      end
      if (pop) begin
        ret_pc_q  <= stk_top[CTX_W-1:IRQ_NUM_W];
        ret_num_q <= stk_top[IRQ_NUM_W-1:0];
      end
    end
  end

  assign handler_pc = PC_WIDTH'(vec_q) << VEC_SHIFT;

  // Pulses are masked while rst is high so an abandoned sequence never leaks an ack/redirect/eoi.
  assign stall_req      = (state_q != ST_IDLE);
  assign irq_ack        = (state_q == ST_ACK) && !rst;
  assign irq_ack_num    = irq_ack ? num_q : '0;
  assign redirect_valid = ((state_q == ST_REDIRECT) || (state_q == ST_RETURN)) && !rst;
  assign redirect_pc    = !redirect_valid ? '0 :
                          (state_q == ST_RETURN) ? ret_pc_q : handler_pc;
  assign eoi_valid      = (state_q == ST_RETURN) && !rst;
  assign eoi_num        = eoi_valid ? ret_num_q : '0;
  assign mret_err       = mret_err_q && !rst;

endmodule

// File: tb/tb_irq_entry_sequencer.sv
// Scoreboard bench for irq_entry_sequencer: stimulus tasks push expected ack/redirect/eoi/error
// events computed from a queue-based context stack; a negedge monitor pops and compares them.
module tb_irq_entry_sequencer;
  localparam int MN = 4;
  localparam int VS = 2;

  logic        clk = 1'b0;
  logic        rst, irq_pending, global_ie, pipe_drained, mret;
  logic [3:0]  irq_num;
  logic [7:0]  irq_vector;
  logic [31:0] resume_pc;
  logic        stall_req, irq_ack, redirect_valid, eoi_valid, mret_err;
  logic [3:0]  irq_ack_num, eoi_num;
  logic [31:0] redirect_pc;
  logic [2:0]  nest_depth;

  int checks = 0;
  int failures = 0;

  logic [31:0] exp_ack_q[$];
  logic [31:0] exp_redir_q[$];
  logic [31:0] exp_eoi_q[$];
  logic [31:0] exp_err_q[$];
  logic [31:0] m_pc[$];
  logic [3:0]  m_num[$];

  irq_entry_sequencer #(
    .VECTOR_WIDTH (8),
    .PC_WIDTH     (32),
    .VEC_SHIFT    (VS),
    .MAX_NEST     (MN)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .irq_pending    (irq_pending),
    .irq_num        (irq_num),
    .irq_vector     (irq_vector),
    .global_ie      (global_ie),
    .pipe_drained   (pipe_drained),
    .resume_pc      (resume_pc),
    .mret           (mret),
    .stall_req      (stall_req),
    .irq_ack        (irq_ack),
    .irq_ack_num    (irq_ack_num),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .eoi_valid      (eoi_valid),
    .eoi_num        (eoi_num),
    .nest_depth     (nest_depth),
    .mret_err       (mret_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (irq_ack) begin
      check("ack_expected", 32'(exp_ack_q.size() != 0), 32'd1);
      if (exp_ack_q.size() != 0) check("ack_num", 32'(irq_ack_num), exp_ack_q.pop_front());
    end
    if (redirect_valid) begin
      check("redirect_expected", 32'(exp_redir_q.size() != 0), 32'd1);
      if (exp_redir_q.size() != 0) check("redirect_pc", redirect_pc, exp_redir_q.pop_front());
    end
    if (eoi_valid) begin
      check("eoi_expected", 32'(exp_eoi_q.size() != 0), 32'd1);
      if (exp_eoi_q.size() != 0) check("eoi_num", 32'(eoi_num), exp_eoi_q.pop_front());
    end
    if (mret_err) begin
      check("mret_err_expected", 32'(exp_err_q.size() != 0), 32'd1);
      if (exp_err_q.size() != 0) void'(exp_err_q.pop_front());
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_stall"}, 32'(stall_req), 32'd0);
    check({tag, "_ack"}, 32'(irq_ack), 32'd0);
    check({tag, "_ack_num"}, 32'(irq_ack_num), 32'd0);
    check({tag, "_redir"}, 32'(redirect_valid), 32'd0);
    check({tag, "_redir_pc"}, redirect_pc, 32'd0);
    check({tag, "_eoi"}, 32'(eoi_valid), 32'd0);
    check({tag, "_eoi_num"}, 32'(eoi_num), 32'd0);
    check({tag, "_depth"}, 32'(nest_depth), 32'd0);
    check({tag, "_mret_err"}, 32'(mret_err), 32'd0);
  endtask

  // IRQ entry: n0 offered while idle and while draining, nf offered on the drained cycle.
  task automatic take_irq(input logic [3:0] n0, input logic [3:0] nf, input logic [7:0] vec,
                          input int wait_c, input logic [31:0] pc);
    irq_pending = 1'b1;
    irq_num     = n0;
    irq_vector  = vec;
    resume_pc   = pc;
    if (m_pc.size() >= MN || !global_ie) begin
      pipe_drained = 1'b1;
      for (int i = 0; i < 3; i++) begin
        step();
        check("ignored_stall", 32'(stall_req), 32'd0);
      end
      irq_pending  = 1'b0;
      pipe_drained = 1'b0;
      check("ignored_depth", 32'(nest_depth), 32'(m_pc.size()));
      return;
    end
    pipe_drained = 1'b0;
    step();
    check("drain_stall", 32'(stall_req), 32'd1);
    for (int i = 0; i < wait_c; i++) begin
      resume_pc = $urandom;
      mret      = ($urandom_range(0, 3) == 0);
      step();
      mret = 1'b0;
      check("drain_hold_stall", 32'(stall_req), 32'd1);
    end
    irq_num      = nf;
    resume_pc    = pc;
    pipe_drained = 1'b1;
    m_pc.push_back(pc);
    m_num.push_back(nf);
    exp_ack_q.push_back(32'(nf));
    exp_redir_q.push_back({24'b0, vec} << VS);
    step();
    irq_pending  = 1'b0;
    pipe_drained = 1'b0;
    check("ack_timing", 32'(irq_ack), 32'd1);
    step();
    check("redirect_timing", 32'(redirect_valid), 32'd1);
    step();
    check("entry_release_stall", 32'(stall_req), 32'd0);
    check("entry_depth", 32'(nest_depth), 32'(m_pc.size()));
  endtask

  task automatic abort_irq(input logic [3:0] n, input int wait_c);
    irq_pending  = 1'b1;
    irq_num      = n;
    irq_vector   = 8'($urandom);
    pipe_drained = 1'b0;
    step();
    check("abort_drain_stall", 32'(stall_req), 32'd1);
    for (int i = 0; i < wait_c; i++) step();
    irq_pending = 1'b0;
    step();
    check("abort_release_stall", 32'(stall_req), 32'd0);
    check("abort_depth", 32'(nest_depth), 32'(m_pc.size()));
  endtask

  task automatic do_mret();
    mret = 1'b1;
    if (m_pc.size() == 0) begin
      exp_err_q.push_back(32'd1);
      step();
      mret = 1'b0;
      check("mret_err_pulse", 32'(mret_err), 32'd1);
      check("mret_err_no_redirect", 32'(redirect_valid), 32'd0);
      check("mret_err_no_stall", 32'(stall_req), 32'd0);
      step();
      check("mret_err_one_cycle", 32'(mret_err), 32'd0);
    end else begin
      exp_redir_q.push_back(m_pc.pop_back());
      exp_eoi_q.push_back(32'(m_num.pop_back()));
      step();
      mret = 1'b0;
      check("return_stall", 32'(stall_req), 32'd1);
      check("return_eoi_timing", 32'(eoi_valid), 32'd1);
      step();
      check("return_release_stall", 32'(stall_req), 32'd0);
      check("return_depth", 32'(nest_depth), 32'(m_pc.size()));
    end
  endtask

  task automatic reset_in_ack();
    irq_pending  = 1'b1;
    irq_num      = 4'($urandom);
    irq_vector   = 8'($urandom);
    resume_pc    = $urandom;
    pipe_drained = 1'b1;
    step();
    step();
    rst = 1'b1;
    #1;
    check("rst_in_ack_no_ack", 32'(irq_ack), 32'd0);
    irq_pending  = 1'b0;
    pipe_drained = 1'b0;
    step();
    rst = 1'b0;
    m_pc.delete();
    m_num.delete();
    #1;
    check_all_zero("rst_in_ack");
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached with checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; irq_pending = 1'b0; global_ie = 1'b1; pipe_drained = 1'b0; mret = 1'b0;
    irq_num = '0; irq_vector = '0; resume_pc = '0;
    repeat (3) step();
    check_all_zero("in_reset");
    rst = 1'b0;
    step();
    check_all_zero("after_reset");

    take_irq(4'd5, 4'd5, 8'h10, 0, 32'h0000_1000);
    take_irq(4'd5, 4'd2, 8'h22, 3, 32'h0000_2000);
    abort_irq(4'd7, 2);
    take_irq(4'd3, 4'd3, 8'h33, 1, 32'h0000_3000);
    take_irq(4'd9, 4'd9, 8'hff, 0, 32'h0000_4000);
    take_irq(4'd1, 4'd1, 8'h01, 0, 32'h0000_5000);
    repeat (4) do_mret();
    do_mret();

    take_irq(4'd6, 4'd6, 8'h44, 0, 32'h0000_6000);
    irq_pending = 1'b1; irq_num = 4'hc; irq_vector = 8'h55;
    do_mret();
    take_irq(4'hc, 4'hc, 8'h55, 0, 32'h0000_7000);
    do_mret();

    take_irq(4'd8, 4'd8, 8'h12, 0, 32'h0000_8000);
    reset_in_ack();

    repeat (80) begin
      int r;
      r = $urandom_range(0, 9);
      if (r <= 3) begin
        take_irq(4'($urandom), 4'($urandom), 8'($urandom), $urandom_range(0, 3), $urandom);
      end else if (r == 4) begin
        if (m_pc.size() < MN) abort_irq(4'($urandom), $urandom_range(0, 2));
      end else if (r <= 7) begin
        do_mret();
      end else if (r == 8) begin
        global_ie = 1'b0;
        take_irq(4'($urandom), 4'($urandom), 8'($urandom), 0, $urandom);
        global_ie = 1'b1;
      end else if (m_pc.size() > 0) begin
        logic [3:0] n;
        logic [7:0] v;
        n = 4'($urandom);
        v = 8'($urandom);
        irq_pending = 1'b1; irq_num = n; irq_vector = v;
        do_mret();
        take_irq(n, n, v, $urandom_range(0, 2), $urandom);
      end
    end

    repeat (2) step();
    check("ack_q_empty", 32'(exp_ack_q.size()), 32'd0);
    check("redir_q_empty", 32'(exp_redir_q.size()), 32'd0);
    check("eoi_q_empty", 32'(exp_eoi_q.size()), 32'd0);
    check("err_q_empty", 32'(exp_err_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
